// File: rtl/ctrl_sequencer_pkg.sv
// Shared encodings for the control sequencer: state-bus values,
// opcodes and the opcode legality check.
package ctrl_sequencer_pkg;

    typedef enum logic [7:0] {
        STATE_RESET      = 8'h00,
        STATE_FETCH_PC   = 8'h01,
        STATE_FETCH_INST = 8'h02,
        STATE_NEXT       = 8'h03,
        STATE_HALT       = 8'h04,
        STATE_MOV_REG    = 8'h05,
        STATE_SET_REG    = 8'h06,
        STATE_LOAD_ADDR  = 8'h07,
        STATE_SET_MEM    = 8'h08,
        STATE_ALU_EXEC   = 8'h09,
        STATE_ALU_OUT    = 8'h0A,
        STATE_FETCH_SP   = 8'h0B,
        STATE_STACK_REG  = 8'h0C,
        STATE_INC_SP     = 8'h0D,
        STATE_JUMP       = 8'h0E,
        STATE_STORE_PC   = 8'h0F,
        STATE_TMP_JUMP   = 8'h10,
        STATE_RET        = 8'h11,
        STATE_SET_MAR    = 8'h12,
        STATE_IRQ_VECTOR = 8'h13
    } state_e;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_HLT  = 8'h01,
        OP_MOV  = 8'h02,
        OP_LDI  = 8'h03,
        OP_LDX  = 8'h04,
        OP_STX  = 8'h05,
        OP_CMP  = 8'h06,
        OP_ALU  = 8'h07,
        OP_PUSH = 8'h08,
        OP_POP  = 8'h09,
        OP_JMP  = 8'h0A,
        OP_CALL = 8'h0B,
        OP_RET  = 8'h0C,
        OP_LDA  = 8'h0D,
        OP_STA  = 8'h0E
    } op_e;

    // Longest per-opcode tail after FETCH_PC/FETCH_INST (CALL).
    localparam int SEQ_LEN = 6;

    function automatic logic op_known(input logic [7:0] op);
        return op <= OP_STA;
    endfunction

endpackage

// File: rtl/ctrl_step_rom.sv
// Combinational micro-step table: (opcode, step) -> state and
// whether that state closes the instruction.
module ctrl_step_rom
    import ctrl_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int STATE_W  = 8,
    parameter int STEP_W   = 4
) (
    input  logic [OPCODE_W-1:0] i_op,
    input  logic [STEP_W-1:0]   i_step,
    output logic [STATE_W-1:0]  o_state,
    output logic                o_last
);

    localparam logic [7:0] N = STATE_NEXT;

    logic [0:SEQ_LEN-1][7:0] w_seq;
    logic [7:0]              w_state;
    logic [2:0]              w_idx;

    // Tails are padded with NEXT so unknown opcodes close at step 2.
    always_comb begin
        w_seq = {SEQ_LEN{N}};
        unique case (i_op)
            OPCODE_W'(OP_HLT):  w_seq = {STATE_HALT, {5{N}}};
            OPCODE_W'(OP_NOP):  w_seq = {SEQ_LEN{N}};
            OPCODE_W'(OP_MOV):  w_seq = {STATE_MOV_REG, {5{N}}};
            OPCODE_W'(OP_LDI):  w_seq = {STATE_FETCH_PC,
                                         STATE_SET_REG, {4{N}}};
            OPCODE_W'(OP_LDX):  w_seq = {STATE_FETCH_PC,
                                         STATE_LOAD_ADDR,
                                         STATE_SET_REG, {3{N}}};
            OPCODE_W'(OP_STX):  w_seq = {STATE_FETCH_PC,
                                         STATE_LOAD_ADDR,
                                         STATE_SET_MEM, {3{N}}};
            OPCODE_W'(OP_CMP):  w_seq = {STATE_ALU_EXEC, {5{N}}};
            OPCODE_W'(OP_ALU):  w_seq = {STATE_ALU_EXEC,
                                         STATE_ALU_OUT, {4{N}}};
            OPCODE_W'(OP_PUSH): w_seq = {STATE_FETCH_SP,
                                         STATE_STACK_REG, {4{N}}};
            OPCODE_W'(OP_POP):  w_seq = {STATE_INC_SP,
                                         STATE_FETCH_SP,
                                         STATE_SET_REG, {3{N}}};
            OPCODE_W'(OP_JMP):  w_seq = {STATE_FETCH_PC,
                                         STATE_JUMP, {4{N}}};
            OPCODE_W'(OP_CALL): w_seq = {STATE_FETCH_PC,
                                         STATE_SET_REG,
                                         STATE_FETCH_SP,
                                         STATE_STORE_PC,
                                         STATE_TMP_JUMP, N};
            OPCODE_W'(OP_RET):  w_seq = {STATE_INC_SP,
                                         STATE_FETCH_SP,
                                         STATE_RET, {3{N}}};
            OPCODE_W'(OP_LDA):  w_seq = {STATE_SET_MAR,
                                         STATE_SET_REG, {4{N}}};
            OPCODE_W'(OP_STA):  w_seq = {STATE_SET_MAR,
                                         STATE_SET_MEM, {4{N}}};
            default:            w_seq = {SEQ_LEN{N}};
        endcase
    end

    assign w_idx = 3'(i_step - STEP_W'(2));

    always_comb begin
        w_state = N;
        unique case (1'b1)
            (i_step == '0):         w_state = STATE_FETCH_PC;
            (i_step == STEP_W'(1)): w_state = STATE_FETCH_INST;
            ((32'(i_step) >= 2) &&
             (32'(i_step) < SEQ_LEN + 2)):
                                    w_state = w_seq[w_idx];
            default:                w_state = N;
        endcase
    end

    assign o_state = STATE_W'(w_state);
    assign o_last  = (w_state == N);

endmodule

// File: rtl/ctrl_sequencer.sv
// CPU control sequencer: walks each opcode through the step ROM and
// adds stall, halt/resume, interrupt entry and illegal-op traps.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int OPCODE_W  = 8,
    parameter int STATE_W   = 8,
    parameter int STEP_W    = 4,
    parameter int MAX_STEPS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                resume,
    input  logic                irq,
    output logic [STATE_W-1:0]  state,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
    output logic                irq_ack,
    output logic                illegal,
    output logic                halted
);

    localparam logic [STATE_W-1:0] L_RST  = STATE_W'(STATE_RESET);
    localparam logic [STATE_W-1:0] L_PC   = STATE_W'(STATE_FETCH_PC);
    localparam logic [STATE_W-1:0] L_NEXT = STATE_W'(STATE_NEXT);
    localparam logic [STATE_W-1:0] L_HALT = STATE_W'(STATE_HALT);
    localparam logic [STATE_W-1:0] L_SP   = STATE_W'(STATE_FETCH_SP);
    localparam logic [STATE_W-1:0] L_STPC = STATE_W'(STATE_STORE_PC);
    localparam logic [STATE_W-1:0] L_VEC  = STATE_W'(STATE_IRQ_VECTOR);

    logic [STATE_W-1:0]  r_state, w_nstate, w_rom_state;
    logic [STEP_W-1:0]   r_step, w_nstep;
    logic [STEP_W:0]     w_inc;
    logic [OPCODE_W-1:0] r_op_q, w_op;
    logic r_in_irq, r_done, r_ack, r_ill, r_halted;
    logic w_nirq, w_ack, w_ill, w_rom_last;
    logic w_boot, w_bound, w_halt, w_isr, w_run;
    logic w_decode, w_bad_op;

    assign w_boot   = (r_state == L_RST);
    assign w_bound  = (r_state == L_NEXT);
    assign w_halt   = (r_state == L_HALT);
    assign w_isr    = r_in_irq && !w_bound && !w_boot && !w_halt;
    assign w_run    = !(w_boot || w_bound || w_halt || w_isr);
    assign w_inc    = {1'b0, r_step} + (STEP_W+1)'(1);
    assign w_decode = (r_step == STEP_W'(1));
    assign w_op     = w_decode ? opcode : r_op_q;
    assign w_bad_op = ((opcode >> 8) != '0) ||
                      !op_known(8'(opcode));

    ctrl_step_rom #(
        .OPCODE_W (OPCODE_W),
        .STATE_W  (STATE_W),
        .STEP_W   (STEP_W)
    ) u_rom (
        .i_op    (w_op),
        .i_step  (w_inc[STEP_W-1:0]),
        .o_state (w_rom_state),
        .o_last  (w_rom_last)
    );

    always_comb begin
        w_nstate = r_state;
        w_nstep  = r_step;
        w_nirq   = r_in_irq;
        w_ack    = 1'b0;
        w_ill    = 1'b0;
        unique case (1'b1)
            w_boot: begin
                w_nstate = L_PC;
                w_nstep  = '0;
            end
            // Instruction boundary; the ISR's own NEXT clears in_irq.
            w_bound: begin
                w_nstep = '0;
                if (irq && !r_in_irq) begin
                    w_nstate = L_SP;
                    w_nirq   = 1'b1;
                    w_ack    = 1'b1;
                end else begin
                    w_nstate = L_PC;
                    w_nirq   = 1'b0;
                end
            end
            w_halt: begin
                if (resume) begin
                    w_nstate = L_NEXT;
                    w_nstep  = w_inc[STEP_W-1:0];
                end
            end
            w_isr: begin
                w_nstep  = w_inc[STEP_W-1:0];
                w_nstate = (r_step == '0)         ? L_STPC :
                           (r_step == STEP_W'(1)) ? L_VEC  : L_NEXT;
            end
            default: begin
                w_nstep  = w_inc[STEP_W-1:0];
                w_nstate = w_rom_state;
                w_ill    = w_decode && w_bad_op;
                if (w_inc == (STEP_W+1)'(MAX_STEPS) && !w_rom_last) begin
                    w_nstate = L_NEXT;
                    w_ill    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= L_RST;
            r_step   <= '0;
            r_op_q   <= '0;
            r_in_irq <= 1'b0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_ill    <= 1'b0;
            r_halted <= 1'b0;
        end else if (!stall) begin
            r_state  <= w_nstate;
            r_step   <= w_nstep;
            r_in_irq <= w_nirq;
            r_done   <= (w_nstate == L_NEXT);
            r_ack    <= w_ack;
            r_ill    <= w_ill;
            r_halted <= (w_nstate == L_HALT);
            if (w_run && w_decode) begin
                r_op_q <= opcode;
            end
        end
    end

    assign state      = r_state;
    assign step       = r_step;
    assign instr_done = r_done;
    assign irq_ack    = r_ack;
    assign illegal    = r_ill;
    assign halted     = r_halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: hand-written state/flag
// sequences for each instruction class, stall, halt, irq and reset.
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] opcode;
    logic       stall, resume, irq;
    logic [7:0] state;
    logic [3:0] step;
    logic       instr_done, irq_ack, illegal, halted;

    int n_tot = 0;
    int n_bad = 0;

    ctrl_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .stall      (stall),
        .resume     (resume),
        .irq        (irq),
        .state      (state),
        .step       (step),
        .instr_done (instr_done),
        .irq_ack    (irq_ack),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // fl = {instr_done, irq_ack, illegal, halted}
    task automatic cyc(input string tag, input logic [7:0] st,
                       input logic [3:0] fl);
        @(posedge clk);
        #1;
        chk({tag, "_st"}, 32'(state), 32'(st));
        chk({tag, "_fl"}, 32'({instr_done, irq_ack, illegal, halted}),
            32'(fl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        opcode  = 8'h00;
        stall   = 1'b0;
        resume  = 1'b0;
        irq     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'h00);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_flags", 32'({instr_done, irq_ack, illegal, halted}),
            32'h0);
        reset_n = 1'b1;

        // NOP
        opcode = OP_NOP;
        cyc("nop0", STATE_FETCH_PC, 4'b0000);
        chk("nop0_step", 32'(step), 32'h0);
        cyc("nop1", STATE_FETCH_INST, 4'b0000);
        cyc("nop2", STATE_NEXT, 4'b1000);
        cyc("nop3", STATE_FETCH_PC, 4'b0000);

        // CALL, opcode corrupted after decode
        opcode = OP_CALL;
        cyc("call1", STATE_FETCH_INST, 4'b0000);
        cyc("call2", STATE_FETCH_PC, 4'b0000);
        opcode = 8'hFF;
        cyc("call3", STATE_SET_REG, 4'b0000);
        cyc("call4", STATE_FETCH_SP, 4'b0000);
        cyc("call5", STATE_STORE_PC, 4'b0000);
        cyc("call6", STATE_TMP_JUMP, 4'b0000);
        cyc("call7", STATE_NEXT, 4'b1000);
        chk("call7_step", 32'(step), 32'h7);
        cyc("call8", STATE_FETCH_PC, 4'b0000);

        // LDX with 3-cycle stall at step 3
        opcode = OP_LDX;
        cyc("ldx1", STATE_FETCH_INST, 4'b0000);
        cyc("ldx2", STATE_FETCH_PC, 4'b0000);
        cyc("ldx3", STATE_LOAD_ADDR, 4'b0000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("ldx_stall", STATE_LOAD_ADDR, 4'b0000);
            chk("ldx_stall_step", 32'(step), 32'h3);
        end
        stall = 1'b0;
        cyc("ldx4", STATE_SET_REG, 4'b0000);
        cyc("ldx5", STATE_NEXT, 4'b1000);
        cyc("ldx6", STATE_FETCH_PC, 4'b0000);

        // HLT, resume after 5 halted cycles
        opcode = OP_HLT;
        cyc("hlt1", STATE_FETCH_INST, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cyc("hlt_hold", STATE_HALT, 4'b0001);
        end
        resume = 1'b1;
        cyc("hlt_next", STATE_NEXT, 4'b1000);
        resume = 1'b0;
        cyc("hlt_pc", STATE_FETCH_PC, 4'b0000);

        // ALU with irq raised mid-instruction
        opcode = OP_ALU;
        cyc("alu1", STATE_FETCH_INST, 4'b0000);
        irq = 1'b1;
        cyc("alu2", STATE_ALU_EXEC, 4'b0000);
        cyc("alu3", STATE_ALU_OUT, 4'b0000);
        cyc("alu4", STATE_NEXT, 4'b1000);
        cyc("isr0", STATE_FETCH_SP, 4'b0100);
        cyc("isr1", STATE_STORE_PC, 4'b0000);
        cyc("isr2", STATE_IRQ_VECTOR, 4'b0000);
        cyc("isr3", STATE_NEXT, 4'b1000);
        cyc("isr_pc", STATE_FETCH_PC, 4'b0000);
        irq = 1'b0;

        // Unknown opcode
        opcode = 8'hEE;
        cyc("bad1", STATE_FETCH_INST, 4'b0000);
        cyc("bad2", STATE_NEXT, 4'b1010);
        cyc("bad3", STATE_FETCH_PC, 4'b0000);

        // Async reset mid-CALL
        opcode = OP_CALL;
        cyc("rcall1", STATE_FETCH_INST, 4'b0000);
        cyc("rcall2", STATE_FETCH_PC, 4'b0000);
        cyc("rcall3", STATE_SET_REG, 4'b0000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'h00);
        chk("async_step", 32'(step), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
